// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its storage array.
package mem_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array. Write is unconditional on i_we, and
// the read data is registered. Only the read register is reset; the
// storage itself keeps its contents across reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int WIDTH     = WORD_SIZE_DEFAULT,
  parameter int ADDR_BITS = 8,
  parameter int DEPTH     = 1 << ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [WIDTH-1:0]     i_wdata,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage write; never cleared so contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read port; holds its last value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_responder.sv
// Memory endpoint answering CPU read/write request levels after a fixed
// latency with a one-cycle response pulse.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for read_m / write_m
//   BUSY  | request latched, counting down the latency
//   RESP  | response pulse is high this cycle
//   HOLD  | waiting for the CPU to drop its request before re-arming
module memory_responder
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 input_ready,
  output logic                 ack_output,
  output logic                 busy,
  output logic                 protocol_err
);

  localparam int                CNT_BITS = 4;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_BITS-1:0]   r_cnt;
  op_t                   r_op;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic                  r_input_ready;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_perr;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_we;
  logic                  w_re;

  // Upper address bits alias away; fold them into a sink net.
  generate
    if (WORD_SIZE > ADDR_BITS) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
    end
  endgenerate

  // Next-state decode plus accept/fire strobes.
  always_comb begin
    w_req        = read_m | write_m;
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_fire       = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = w_req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!w_req) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Reset at the firing edge must drop the pending access entirely.
  assign w_we = w_fire && (r_op == OP_WRITE) && !reset;
  assign w_re = w_fire && (r_op == OP_READ)  && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request latches, latency counter, response pulses and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_op          <= OP_READ;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_input_ready <= 1'b0;
      r_ack         <= 1'b0;
      r_busy        <= 1'b0;
      r_perr        <= 1'b0;
    end else begin
      r_input_ready <= w_fire && (r_op == OP_READ);
      r_ack         <= w_fire && (r_op == OP_WRITE);
      r_busy        <= (w_state_next != IDLE);
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_op    <= read_m ? OP_READ : OP_WRITE;
        r_addr  <= address[ADDR_BITS-1:0];
        r_wdata <= data_in;
        if (read_m && write_m) begin
          r_perr <= 1'b1;
        end
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  mem_array #(
    .WIDTH     (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS),
    .DEPTH     (1 << ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (data_out)
  );

  assign input_ready  = r_input_ready;
  assign ack_output   = r_ack;
  assign busy         = r_busy;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance at LATENCY=2 and one
// at LATENCY=1, driven from a per-cycle vector table plus a hand-written
// request-hold sequence.
module tb_memory_responder;

  localparam int L0 = 2;
  localparam int L1 = 1;

  logic        clk;
  logic        rst0, rd0, wr0;
  logic [15:0] addr0, din0, dout0;
  logic        ir0, ack0, busy0, perr0;
  logic        rst1, rd1, wr1;
  logic [15:0] addr1, din1, dout1;
  logic        ir1, ack1, busy1, perr1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] e_dout;
    logic        e_ir;
    logic        e_ack;
    logic        e_busy;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];

  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(L0)) u0 (
    .clk(clk), .reset(rst0), .read_m(rd0), .write_m(wr0),
    .address(addr0), .data_in(din0), .data_out(dout0),
    .input_ready(ir0), .ack_output(ack0), .busy(busy0), .protocol_err(perr0)
  );

  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(L1)) u1 (
    .clk(clk), .reset(rst1), .read_m(rd1), .write_m(wr1),
    .address(addr1), .data_in(din1), .data_out(dout1),
    .input_ready(ir1), .ack_output(ack1), .busy(busy1), .protocol_err(perr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check16(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check1(input string name, input int idx, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input int sel, input int rst, input int rd, input int wr,
                     input int addr, input int din, input int e_dout,
                     input int e_ir, input int e_ack, input int e_busy, input int e_perr);
    vec_t v;
    v.sel    = (sel != 0);
    v.rst    = (rst != 0);
    v.rd     = (rd != 0);
    v.wr     = (wr != 0);
    v.addr   = 16'(addr);
    v.din    = 16'(din);
    v.e_dout = 16'(e_dout);
    v.e_ir   = (e_ir != 0);
    v.e_ack  = (e_ack != 0);
    v.e_busy = (e_busy != 0);
    v.e_perr = (e_perr != 0);
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    rst0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; addr0 = 16'h0; din0 = 16'h0;
    rst1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 16'h0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    idle_inputs();
    if (!v.sel) begin
      rst0 = v.rst; rd0 = v.rd; wr0 = v.wr; addr0 = v.addr; din0 = v.din;
    end else begin
      rst1 = v.rst; rd1 = v.rd; wr1 = v.wr; addr1 = v.addr; din1 = v.din;
    end
    @(posedge clk);
    #1;
    if (!v.sel) begin
      check16("u0 data_out", idx, dout0, v.e_dout);
      check1("u0 input_ready", idx, ir0, v.e_ir);
      check1("u0 ack_output", idx, ack0, v.e_ack);
      check1("u0 busy", idx, busy0, v.e_busy);
      check1("u0 protocol_err", idx, perr0, v.e_perr);
    end else begin
      check16("u1 data_out", idx, dout1, v.e_dout);
      check1("u1 input_ready", idx, ir1, v.e_ir);
      check1("u1 ack_output", idx, ack1, v.e_ack);
      check1("u1 busy", idx, busy1, v.e_busy);
      check1("u1 protocol_err", idx, perr1, v.e_perr);
    end
  endtask

  // Edges from (and including) the accept edge until input_ready is seen.
  task automatic wait_ready0(output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ir0) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready0: got no input_ready within 20 edges want pulse");
    end
  endtask

  initial begin
    int edges;
    idle_inputs();
    rst0 = 1'b1;
    rst1 = 1'b1;

    //  sel rst rd wr addr     din       dout     ir ack busy perr
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    // write 0x1234 -> 0x0010
    add(0, 0, 0, 1, 16'h0010, 16'h1234, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0010, 16'h1234, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0010, 16'h1234, 16'h0000, 0, 1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    // read 0x0010; address changes after accept must be ignored
    add(0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0055, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0055, 16'h0000, 16'h1234, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0);
    // alias: write 0xAAAA -> 0x01FF, read 0x00FF
    add(0, 0, 0, 1, 16'h01FF, 16'hAAAA, 16'h1234, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h01FF, 16'hAAAA, 16'h1234, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h01FF, 16'hAAAA, 16'h1234, 0, 1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0);
    add(0, 0, 1, 0, 16'h00FF, 16'h0000, 16'h1234, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h00FF, 16'h0000, 16'h1234, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h00FF, 16'h0000, 16'hAAAA, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hAAAA, 0, 0, 0, 0);
    // preload 0x00A0 -> 0x0005
    add(0, 0, 0, 1, 16'h0005, 16'h00A0, 16'hAAAA, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0005, 16'h00A0, 16'hAAAA, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0005, 16'h00A0, 16'hAAAA, 0, 1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hAAAA, 0, 0, 0, 0);
    // read and write together: treated as read, error flag sticks
    add(0, 0, 1, 1, 16'h0005, 16'hFFFF, 16'hAAAA, 0, 0, 1, 1);
    add(0, 0, 1, 1, 16'h0005, 16'hFFFF, 16'hAAAA, 0, 0, 1, 1);
    add(0, 0, 1, 1, 16'h0005, 16'hFFFF, 16'h00A0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h00A0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 16'h0005, 16'h0000, 16'h00A0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 16'h0005, 16'h0000, 16'h00A0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 16'h0005, 16'h0000, 16'h00A0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h00A0, 0, 0, 0, 1);
    // preload 0x1111 -> 0x0020
    add(0, 0, 0, 1, 16'h0020, 16'h1111, 16'h00A0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 16'h0020, 16'h1111, 16'h00A0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 16'h0020, 16'h1111, 16'h00A0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h00A0, 0, 0, 0, 1);
    // write 0xBEEF -> 0x0020, reset on the edge that would commit it
    add(0, 0, 0, 1, 16'h0020, 16'hBEEF, 16'h00A0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 16'h0020, 16'hBEEF, 16'h00A0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 16'h0020, 16'hBEEF, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0020, 16'h0000, 16'h1111, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1111, 0, 0, 0, 0);
    // reset during the response cycle kills the pulse
    add(0, 0, 1, 0, 16'h0010, 16'h0000, 16'h1111, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0010, 16'h0000, 16'h1111, 0, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 1, 0, 1, 0);
    add(0, 1, 1, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    // LATENCY=1 instance: write 0x0001 -> 0x0003, reads back-to-back
    add(1, 0, 0, 1, 16'h0003, 16'h0001, 16'h0000, 0, 0, 1, 0);
    add(1, 0, 0, 1, 16'h0003, 16'h0001, 16'h0000, 0, 1, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h0003, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(1, 0, 1, 0, 16'h0003, 16'h0000, 16'h0001, 1, 0, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h0003, 16'h0000, 16'h0001, 0, 0, 1, 0);
    add(1, 0, 1, 0, 16'h0003, 16'h0000, 16'h0001, 1, 0, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 0);
    // LATENCY=1: write held through HOLD, aliased address 0x0103 -> 0x03
    add(1, 0, 0, 1, 16'h0103, 16'h0005, 16'h0001, 0, 0, 1, 0);
    add(1, 0, 0, 1, 16'h0103, 16'h0005, 16'h0001, 0, 1, 1, 0);
    add(1, 0, 0, 1, 16'h0103, 16'h0005, 16'h0001, 0, 0, 1, 0);
    add(1, 0, 0, 1, 16'h0103, 16'h0005, 16'h0001, 0, 0, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h0003, 16'h0000, 16'h0001, 0, 0, 1, 0);
    add(1, 0, 1, 0, 16'h0003, 16'h0000, 16'h0005, 1, 0, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i], i);
    end

    // Held read request: exactly one pulse, then a fresh one after a drop.
    @(negedge clk);
    idle_inputs();
    rd0   = 1'b1;
    addr0 = 16'h0010;
    wait_ready0(edges);
    if (edges > 0) begin
      check16("hold first latency", 0, 16'(edges - 1), 16'(L0));
      check16("hold first data", 0, dout0, 16'h1234);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check1("hold no repeat pulse", k, ir0, 1'b0);
      check1("hold busy", k, busy0, 1'b1);
    end
    @(negedge clk);
    rd0 = 1'b0;
    @(posedge clk);
    #1;
    check1("hold release busy", 0, busy0, 1'b0);
    @(negedge clk);
    rd0   = 1'b1;
    addr0 = 16'h00FF;
    wait_ready0(edges);
    if (edges > 0) begin
      check16("hold second latency", 0, 16'(edges - 1), 16'(L0));
      check16("hold second data", 0, dout0, 16'hAAAA);
    end
    @(negedge clk);
    rd0 = 1'b0;
    @(posedge clk);
    #1;
    check1("hold final busy", 0, busy0, 1'b0);
    check1("hold final ready", 0, ir0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Synthesizable memory endpoint that answers the CPU's `read_m`/`write_m` requests. The control unit's `mem_read`/`mem_write` decisions become these requests through the datapath. The block stores 16-bit words in a local array and answers each accepted request after a fixed `LATENCY`: a one-cycle `input_ready` pulse for a read, or a one-cycle `ack_output` pulse for a write. It replaces the behavioural testbench memory so the same CPU can be synthesized and exercised against a realistic, multi-cycle responder.

## Interface
- `WORD_SIZE`, 16, data and address width in bits
- `ADDR_BITS`, 8, array index width; depth = 2^`ADDR_BITS` words
- `LATENCY`, 2, edges from request accept to response; legal range 1..15
- `clk`  input  1  single clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `read_m`  input  1  read request level, held by the CPU until it sees `input_ready`
- `write_m`  input  1  write request level, held by the CPU until it sees `ack_output`
- `address`  input  `WORD_SIZE`  word address; only the low `ADDR_BITS` bits are used
- `data_in`  input  `WORD_SIZE`  write data
- `data_out`  output  `WORD_SIZE`  read data, registered, holds its value between reads
- `input_ready`  output  1  one-cycle read-response pulse
- `ack_output`  output  1  one-cycle write-response pulse
- `busy`  output  1  high in every state except IDLE
- `protocol_err`  output  1  sticky; set when `read_m` and `write_m` are both high at accept

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: counting down the latency.
  - RESP: response cycle.
  - HOLD: waiting for the CPU to release its request.
- IDLE:
  - If `read_m` or `write_m` is sampled high, latch the operation, `address[ADDR_BITS-1:0]` and `data_in`.
  - Load the counter with `LATENCY-1` and go to BUSY.
  - If both requests are high, perform a read and set `protocol_err`.
- BUSY:
  - While the counter is nonzero, decrement it each edge.
  - At the edge where the counter is 0, go to RESP.
  - At that same edge, a write updates the array; a read loads `data_out` from the array and asserts `input_ready`. A write asserts `ack_output` instead.
- Request inputs, address and data are ignored after accept. Latched values are used even if the CPU changes or drops them.
- RESP (exactly one cycle):
  - On the next edge, clear the pulse.
  - Go to IDLE if `read_m` and `write_m` are both low; otherwise go to HOLD.
- HOLD: go to IDLE once both requests are sampled low. This guarantees one response per request assertion.
- Array contents are not cleared by reset. Contents are undefined until written.
- `address` bits above `ADDR_BITS` are ignored, so addresses alias modulo 2^`ADDR_BITS`.

## Timing
- Reset values: state IDLE, `data_out`=0, `input_ready`=0, `ack_output`=0, `busy`=0, `protocol_err`=0, counter 0.
- Accept at edge E0 puts the response pulse high in the cycle after edge E0+`LATENCY`.
  - `LATENCY`=1: pulse after E1.
  - `LATENCY`=2: pulse after E2.
- The array write commits at the same edge the `ack_output` pulse rises. A read accepted on the cycle after the write returns the new data.
- Minimum spacing between accepts is `LATENCY`+2 edges: one for RESP, plus at least one IDLE sample with both requests low.
- Reset asserted in BUSY: the pending write is dropped (array unchanged), no pulse is produced, and state goes to IDLE at that edge.
- Reset asserted in RESP: the pulse drops at that edge.
- `busy` is a registered state decode with no combinational path from inputs to any output.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, BUSY, RESP, HOLD}
  - `WORD_SIZE` default constant
  - op encoding {OP_READ, OP_WRITE}
- Sub-module `mem_array`: single-port synchronous array with write enable, registered read, and a depth parameter.
- FSM, counter and latches live in `memory_responder`.

## Test plan
- Write/read round trip, `LATENCY`=2:
  - Write 0x1234 to address 0x0010 → `ack_output` high exactly one cycle, 2 edges after accept.
  - Then read 0x0010 → `input_ready` one cycle and `data_out`=0x1234.
- Request held for 5 cycles after `input_ready` → no second pulse. Drop `read_m` for one cycle, reassert → a new response arrives `LATENCY` edges later.
- `read_m`=`write_m`=1 with `data_in`=0xFFFF at 0x0005 (array holding 0x00A0) → read response with `data_out`=0x00A0 and array unchanged. `protocol_err`=1 and stays 1 until reset.
- Reset pulsed in BUSY during a write of 0xBEEF to 0x0020 (previously 0x1111) → no `ack_output`, all outputs back to reset values. A later read of 0x0020 returns 0x1111.
- Aliasing, `ADDR_BITS`=8: write 0xAAAA to 0x01FF → a read of 0x00FF returns 0xAAAA.
- `LATENCY`=1, back-to-back:
  - Sequence: write 0x0001→0x0003, release, read 0x0003, release.
  - Each pulse appears 1 edge after its accept, and reads return 0x0001.
  - `busy` is low only in IDLE cycles.
